// File: rtl/matrix_scan_sequencer_pkg.sv
// Shared types and constants for the matrix scan sequencer.
package matrix_scan_sequencer_pkg;

  localparam int IDX_W         = 3;
  localparam int CNT_W         = 8;

  localparam int NCOL_DEF      = 5;
  localparam int NROW_DEF      = 7;
  localparam int BLANK_CYC_DEF = 1;
  localparam int DWELL_CYC_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DWELL = 2'd2
  } state_e;

endpackage

// File: rtl/scan_dwell_timer.sv
// Phase cycle counter: cleared by load, otherwise counts up; tc flags the
// last cycle of the current phase.
module scan_dwell_timer
  import matrix_scan_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // clear on load, otherwise advance one per cycle
  always_comb begin
    cnt_d = load ? '0 : cnt_q + CNT_W'(1);
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/matrix_scan_sequencer.sv
// Column-first matrix scanner with a blanking phase ahead of each dwell.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | parked; position held, outputs blanked
// ST_BLANK | blanking window, BLANK_CYC cycles; position just changed
// ST_DWELL | position displayed for DWELL_CYC cycles, then advance
module matrix_scan_sequencer
  import matrix_scan_sequencer_pkg::*;
#(
  parameter int NCOL      = NCOL_DEF,
  parameter int NROW      = NROW_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF,
  parameter int DWELL_CYC = DWELL_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  output logic [IDX_W-1:0] mdc,
  output logic [IDX_W-1:0] mdl,
  output logic             blank,
  output logic             busy,
  output logic             frame_done
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] mdc_q, mdc_d;
  logic [IDX_W-1:0] mdl_q, mdl_d;
  logic             frame_done_q, frame_done_d;
  logic             tmr_load;
  logic             tmr_tc;
  logic [CNT_W-1:0] tmr_tc_val;

  // terminal count depends on which phase is running
  always_comb begin
    tmr_tc_val = (state_q == ST_DWELL) ? CNT_W'(DWELL_CYC - 1) : CNT_W'(BLANK_CYC - 1);
  end

  scan_dwell_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .tc_val (tmr_tc_val),
    .tc     (tmr_tc)
  );

  // next state, position advance and frame pulse; restart overrides last
  always_comb begin
    state_d      = state_q;
    mdc_d        = mdc_q;
    mdl_d        = mdl_q;
    frame_done_d = 1'b0;
    tmr_load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_load = 1'b1;
        if (en) state_d = ST_BLANK;
      end
      ST_BLANK: begin
        if (!en) begin
          state_d  = ST_IDLE;
          tmr_load = 1'b1;
        end else if (tmr_tc) begin
          state_d  = ST_DWELL;
          tmr_load = 1'b1;
        end
      end
      ST_DWELL: begin
        if (!en) begin
          state_d  = ST_IDLE;
          tmr_load = 1'b1;
        end else if (tmr_tc) begin
          state_d  = ST_BLANK;
          tmr_load = 1'b1;
          if (mdc_q == IDX_W'(NCOL - 1)) begin
            mdc_d = '0;
            if (mdl_q == IDX_W'(NROW - 1)) begin
              mdl_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              mdl_d = mdl_q + IDX_W'(1);
            end
          end else begin
            mdc_d = mdc_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tmr_load = 1'b1;
      end
    endcase
    if (restart) begin
      mdc_d        = '0;
      mdl_d        = '0;
      frame_done_d = 1'b0;
      tmr_load     = 1'b1;
      state_d      = en ? ST_BLANK : ST_IDLE;
    end
  end

  // state and position registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mdc_q        <= '0;
      mdl_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mdc_q        <= mdc_d;
      mdl_q        <= mdl_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign mdc        = mdc_q;
  assign mdl        = mdl_q;
  assign blank      = (state_q != ST_DWELL);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: doc/matrix_scan_sequencer.md
MATRIX_SCAN_SEQUENCER -- requirements
Module: matrix_scan_sequencer

Interface
REQ-001 Parameter NCOL, default 5: number of matrix columns scanned; legal range 1..8.
REQ-002 Parameter NROW, default 7: number of matrix rows scanned; legal range 1..8.
REQ-003 Parameter BLANK_CYC, default 1: blanking cycles per position; legal range 1..255.
REQ-004 Parameter DWELL_CYC, default 4: display cycles per position; legal range 1..255.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 en  input  1  scan enable; 1 = run, 0 = park.
REQ-008 restart  input  1  synchronous one-cycle request to return the scan to position (0,0).
REQ-009 mdc  output  3  current column index; drives the downstream 1-of-8 selector column input.
REQ-010 mdl  output  3  current row index; drives the downstream selector row input.
REQ-011 blank  output  1  1 = outputs to the matrix must be suppressed.
REQ-012 busy  output  1  1 while state is BLANK or DWELL.
REQ-013 frame_done  output  1  one-cycle pulse on completion of a full frame.

Function
REQ-014 States SHALL be IDLE, BLANK and DWELL, with a registered 8-bit cycle counter cnt.
REQ-015 In IDLE with en=1, the next state SHALL be BLANK with cnt=0.
REQ-016 In IDLE with en=0, the block SHALL stay in IDLE and hold mdc/mdl.
REQ-017 BLANK SHALL last exactly BLANK_CYC cycles, then move to DWELL with cnt=0.
REQ-018 DWELL SHALL last exactly DWELL_CYC cycles, then advance the position and return to BLANK.
REQ-019 Each position SHALL occupy BLANK_CYC+DWELL_CYC cycles.
REQ-020 Advance order SHALL be column first: mdc increments; when mdc=NCOL-1, mdc becomes 0 and mdl increments.
REQ-021 When mdc=NCOL-1 and mdl=NROW-1 at an advance, both SHALL wrap to 0.
REQ-022 frame_done SHALL be 1 for exactly the first cycle showing (0,0) after a wrap, and 0 at all other times.
REQ-023 blank SHALL be 1 in IDLE and BLANK and 0 in DWELL.
REQ-024 busy SHALL be the complement of the IDLE state indication.
REQ-025 mdc/mdl SHALL change only on the edge that enters BLANK, so a position change is never visible while blank=0.
REQ-026 en=0 sampled in BLANK or DWELL SHALL move the block to IDLE on the next edge with mdc/mdl held and no advance.
REQ-027 A later en=1 SHALL resume at the held position, starting with a full BLANK.
REQ-028 restart=1 SHALL set mdc=0, mdl=0 and cnt=0 on the next edge, with no frame_done pulse.
REQ-029 After restart, the state SHALL be BLANK if en=1, else IDLE.
REQ-030 restart SHALL take priority over a coincident advance or wrap.
REQ-031 en=0 SHALL take priority over restart for the state, but the position SHALL still clear.
REQ-032 Outputs mdc and mdl SHALL never exceed NCOL-1 and NROW-1 respectively.
REQ-033 All outputs SHALL be registered or decoded only from state; there SHALL be no combinational path from en or restart to any output.

Reset
REQ-034 rst=1 SHALL, on the next edge and overriding all other inputs, set: state=IDLE, cnt=0, mdc=0, mdl=0, blank=1, busy=0, frame_done=0.
REQ-035 Reset asserted mid-BLANK or mid-DWELL SHALL abort the position with no advance and no frame_done pulse.

Structure
REQ-036 A shared package SHALL hold the state enum (IDLE/BLANK/DWELL), the 3-bit index width constant and the parameter defaults.
REQ-037 A single sub-module, scan_dwell_timer, SHALL implement cnt with a load/terminal-count interface; the FSM and position counters stay in the top level.

Verification
REQ-038 Scenario: defaults, rst then en=1 held -> blank=1 for 1 cycle, then 0 for 4 cycles; mdc steps 0,1,2,3,4, then 0 with mdl=1; each step takes 5 cycles.
REQ-039 Scenario: defaults, en=1 held -> frame_done pulses once, 175 cycles after first BLANK entry, coincident with (0,0), then every 175 cycles.
REQ-040 Scenario: en dropped in DWELL at (3,2) -> IDLE next edge, blank=1, (3,2) held; en re-raised -> 1 blank + 4 dwell at (3,2), then (4,2).
REQ-041 Scenario: restart coincident with the wrap from (4,6) -> next cycle (0,0), BLANK, frame_done=0.
REQ-042 Scenario: rst asserted mid-DWELL at (2,5), en=1 -> next cycle IDLE, (0,0), blank=1, busy=0; the scan restarts after rst falls.
REQ-043 Scenario: NCOL=1, NROW=1, BLANK_CYC=1, DWELL_CYC=1 -> mdc=mdl=0 always; frame_done pulses every 2 cycles; blank toggles 1,0.
